// File: rtl/sprite_line_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : sprite_line_sequencer
//  Purpose  : Per-scanline walk of the sprite attribute RAM. Each entry is
//             tested for a vertical hit against the prepared line. Hits are
//             handed to the pixel-fetch stage over valid/ready. The block
//             also owns the line-buffer ping-pong select and shares the
//             sprite RAM port with the Z80.
//  Revision : 1.0  initial release
// ============================================================================
module sprite_line_sequencer #(
  parameter int NUM_SPRITES  = 512,
  parameter int MAX_PER_LINE = 32,
  parameter int SPR_HEIGHT   = 16
) (
  input  logic        master_clk,
  input  logic        reset,
  input  logic        line_start,
  input  logic [7:0]  vline,
  output logic [10:0] spr_ram_addr,
  output logic        spr_ram_we,
  output logic [7:0]  spr_ram_din,
  input  logic [7:0]  spr_ram_q,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [10:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic        cpu_ack,
  output logic        draw_valid,
  input  logic        draw_ready,
  output logic [9:0]  draw_idx,
  output logic [3:0]  draw_col,
  output logic [8:0]  draw_hpos,
  output logic [3:0]  draw_row,
  output logic        lb_sel,
  output logic        busy,
  output logic        overflow
);

  localparam int ENTRY_W = $clog2(NUM_SPRITES);
  localparam int HITS_W  = $clog2(MAX_PER_LINE + 1);

  localparam logic [ENTRY_W-1:0] c_last_entry = ENTRY_W'(NUM_SPRITES - 1);
  localparam logic [HITS_W-1:0]  c_max_hits   = HITS_W'(MAX_PER_LINE);
  localparam logic [7:0]         c_height     = 8'(SPR_HEIGHT);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_VPOS = 3'd1,
    S_RD_IDX  = 3'd2,
    S_RD_XDAT = 3'd3,
    S_RD_HPOS = 3'd4,
    S_EMIT    = 3'd5,
    S_NEXT    = 3'd6
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [7:0]         r_vline;
  logic [ENTRY_W-1:0] r_entry;
  logic [HITS_W-1:0]  r_hits;
  logic [3:0]         r_row;
  logic [7:0]         r_idx;
  logic [1:0]         r_xdat_hi;
  logic [3:0]         r_col;
  logic               r_hpos_msb;
  logic [7:0]         r_hpos;
  logic               r_hpos_ok;
  logic               r_lb_sel;
  logic               r_overflow;
  logic               r_cpu_ack;

  logic [10:0] w_base;
  logic [7:0]  w_row;
  logic        w_hit;
  logic        w_grant;
  logic        w_emit;
  logic        w_stop;

  // Byte 0 of the current entry; the RD_* states add their byte offset.
  assign w_base = 11'({r_entry, 2'b00});

  // vpos arrives during RD_IDX; the subtraction wraps at 8 bits so sprites
  // straddling line 255/0 still hit.
  assign w_row = r_vline - spr_ram_q;
  assign w_hit = (w_row < c_height);

  // The Z80 only gets the port in IDLE or in the one NEXT slot per entry,
  // and never twice back to back (the cycle after a grant is its ack).
  assign w_grant = !reset && cpu_req && !r_cpu_ack &&
                   ((r_state == S_IDLE) || (r_state == S_NEXT));

  assign w_emit = (r_state == S_EMIT);
  assign w_stop = (r_entry == c_last_entry) || (r_hits == c_max_hits);

  // hpos is read straight off the RAM in the first EMIT cycle and from the
  // captured copy afterwards, so the field is stable for the whole stall.
  assign draw_valid = w_emit;
  assign draw_idx   = w_emit ? {r_xdat_hi, r_idx} : 10'd0;
  assign draw_col   = w_emit ? r_col : 4'd0;
  assign draw_hpos  = w_emit ? {r_hpos_msb, (r_hpos_ok ? r_hpos : spr_ram_q)} : 9'd0;
  assign draw_row   = w_emit ? r_row : 4'd0;

  assign lb_sel   = r_lb_sel;
  assign overflow = r_overflow;
  assign busy     = (r_state != S_IDLE);
  assign cpu_ack  = r_cpu_ack;
  assign cpu_dout = r_cpu_ack ? spr_ram_q : 8'd0;

  // State register.
  always_ff @(posedge master_clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and RAM port steering.
  always_comb begin
    w_state_nxt  = r_state;
    spr_ram_addr = 11'd0;
    spr_ram_we   = 1'b0;
    spr_ram_din  = 8'd0;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_IDLE;
      end
      S_RD_VPOS: begin
        spr_ram_addr = w_base;
        w_state_nxt  = S_RD_IDX;
      end
      S_RD_IDX: begin
        spr_ram_addr = w_base | 11'd1;
        w_state_nxt  = w_hit ? S_RD_XDAT : S_NEXT;
      end
      S_RD_XDAT: begin
        spr_ram_addr = w_base | 11'd2;
        w_state_nxt  = S_RD_HPOS;
      end
      S_RD_HPOS: begin
        spr_ram_addr = w_base | 11'd3;
        w_state_nxt  = S_EMIT;
      end
      S_EMIT: begin
        if (draw_ready) begin
          w_state_nxt = S_NEXT;
        end
      end
      S_NEXT: begin
        w_state_nxt = w_stop ? S_IDLE : S_RD_VPOS;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    // Grants only happen in states that present no scan address.
    if (w_grant) begin
      spr_ram_addr = cpu_addr;
      spr_ram_we   = cpu_we;
      spr_ram_din  = cpu_din;
    end
    if (line_start) begin
      w_state_nxt = S_RD_VPOS;
    end
  end

  // Scan datapath: line latch, entry/hit counters, field capture, flags.
  always_ff @(posedge master_clk) begin
    if (reset) begin
      r_vline    <= 8'd0;
      r_entry    <= '0;
      r_hits     <= '0;
      r_row      <= 4'd0;
      r_idx      <= 8'd0;
      r_xdat_hi  <= 2'd0;
      r_col      <= 4'd0;
      r_hpos_msb <= 1'b0;
      r_hpos     <= 8'd0;
      r_hpos_ok  <= 1'b0;
      r_lb_sel   <= 1'b0;
      r_overflow <= 1'b0;
      r_cpu_ack  <= 1'b0;
    end else begin
      r_cpu_ack <= w_grant;
      if (line_start) begin
        r_vline    <= vline;
        r_lb_sel   <= ~r_lb_sel;
        r_overflow <= (r_state != S_IDLE);
        r_entry    <= '0;
        r_hits     <= '0;
      end else begin
        case (r_state)
          S_RD_IDX: begin
            if (w_hit) begin
              r_row <= w_row[3:0];
            end
          end
          S_RD_XDAT: begin
            r_idx <= spr_ram_q;
          end
          S_RD_HPOS: begin
            r_xdat_hi  <= spr_ram_q[7:6];
            r_col      <= spr_ram_q[4:1];
            r_hpos_msb <= spr_ram_q[0];
            r_hpos_ok  <= 1'b0;
          end
          S_EMIT: begin
            if (!r_hpos_ok) begin
              r_hpos    <= spr_ram_q;
              r_hpos_ok <= 1'b1;
            end
            if (draw_ready) begin
              r_hits <= r_hits + HITS_W'(1);
            end
          end
          S_NEXT: begin
            r_entry <= r_entry + ENTRY_W'(1);
            if (r_hits == c_max_hits) begin
              r_overflow <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sprite_line_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sprite_line_sequencer
//  Purpose  : Directed self-checking bench for sprite_line_sequencer with a
//             synchronous-read model of the 2 KB sprite attribute RAM.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sprite_line_sequencer;

  logic        master_clk = 1'b0;
  logic        reset;
  logic        line_start;
  logic [7:0]  vline;
  logic [10:0] spr_ram_addr;
  logic        spr_ram_we;
  logic [7:0]  spr_ram_din;
  logic [7:0]  spr_ram_q = 8'h00;
  logic        cpu_req;
  logic        cpu_we;
  logic [10:0] cpu_addr;
  logic [7:0]  cpu_din;
  logic [7:0]  cpu_dout;
  logic        cpu_ack;
  logic        draw_valid;
  logic        draw_ready;
  logic [9:0]  draw_idx;
  logic [3:0]  draw_col;
  logic [8:0]  draw_hpos;
  logic [3:0]  draw_row;
  logic        lb_sel;
  logic        busy;
  logic        overflow;

  sprite_line_sequencer #(
    .NUM_SPRITES  (512),
    .MAX_PER_LINE (32),
    .SPR_HEIGHT   (16)
  ) dut (
    .master_clk   (master_clk),
    .reset        (reset),
    .line_start   (line_start),
    .vline        (vline),
    .spr_ram_addr (spr_ram_addr),
    .spr_ram_we   (spr_ram_we),
    .spr_ram_din  (spr_ram_din),
    .spr_ram_q    (spr_ram_q),
    .cpu_req      (cpu_req),
    .cpu_we       (cpu_we),
    .cpu_addr     (cpu_addr),
    .cpu_din      (cpu_din),
    .cpu_dout     (cpu_dout),
    .cpu_ack      (cpu_ack),
    .draw_valid   (draw_valid),
    .draw_ready   (draw_ready),
    .draw_idx     (draw_idx),
    .draw_col     (draw_col),
    .draw_hpos    (draw_hpos),
    .draw_row     (draw_row),
    .lb_sel       (lb_sel),
    .busy         (busy),
    .overflow     (overflow)
  );

  always #5 master_clk = ~master_clk;

  // Sprite RAM model: every vpos defaults to 0x80, which misses all lines
  // used below. The bench preloads entries through the ld_* side port.
  logic [7:0]  mem [2048] = '{default: 8'h80};
  logic        ld_en = 1'b0;
  logic [10:0] ld_addr = 11'd0;
  logic [7:0]  ld_data = 8'd0;

  always @(posedge master_clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (spr_ram_we) mem[spr_ram_addr] <= spr_ram_din;
    spr_ram_q <= mem[spr_ram_addr];
  end

  // Transfer recorder.
  int         n_xfer = 0;
  logic [9:0] rec_idx  [64];
  logic [3:0] rec_col  [64];
  logic [8:0] rec_hpos [64];
  logic [3:0] rec_row  [64];

  always @(negedge master_clk) begin
    if (draw_valid && draw_ready) begin
      if (n_xfer < 64) begin
        rec_idx[n_xfer]  = draw_idx;
        rec_col[n_xfer]  = draw_col;
        rec_hpos[n_xfer] = draw_hpos;
        rec_row[n_xfer]  = draw_row;
      end
      n_xfer++;
    end
  end

  int   n_cmp = 0;
  int   n_err = 0;
  logic exp_lb = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge master_clk);
    #1;
  endtask

  task automatic poke(input logic [10:0] a, input logic [7:0] d);
    ld_addr = a;
    ld_data = d;
    ld_en   = 1'b1;
    tick();
    ld_en   = 1'b0;
  endtask

  task automatic line_pulse(input logic [7:0] v);
    line_start = 1'b1;
    vline      = v;
    tick();
    line_start = 1'b0;
    exp_lb     = ~exp_lb;
  endtask

  task automatic wait_idle(input string tag, input int budget, output int cyc);
    cyc = 0;
    while (busy && cyc < budget) begin
      cyc++;
      tick();
    end
    if (busy) chk(tag, 64'(busy), 64'd0);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int c;
    c = 0;
    while (!draw_valid && c < budget) begin
      c++;
      tick();
    end
    chk(tag, 64'(draw_valid), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int base;
    int acks;
    logic stable;
    logic [10:0] a0;

    reset = 1'b1; line_start = 1'b0; vline = 8'd0; cpu_req = 1'b0; cpu_we = 1'b0;
    cpu_addr = 11'd0; cpu_din = 8'd0; draw_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset / idle state: every output low.
    chk("reset_outputs", {spr_ram_addr, spr_ram_we, spr_ram_din, cpu_dout, cpu_ack,
                          draw_valid, draw_idx, draw_col, draw_hpos, draw_row,
                          lb_sel, busy, overflow}, 64'd0);

    // Idle CPU write, then read back.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h123; cpu_din = 8'h5A;
    #1;
    chk("cpu_wr_grant", {spr_ram_we, spr_ram_addr, spr_ram_din}, {1'b1, 11'h123, 8'h5A});
    tick();
    chk("cpu_wr_ack", 64'(cpu_ack), 64'd1);
    chk("cpu_no_regrant", 64'(spr_ram_we), 64'd0);
    cpu_req = 1'b0;
    tick();
    chk("cpu_ack_pulse", 64'(cpu_ack), 64'd0);
    cpu_req = 1'b1; cpu_we = 1'b0;
    tick();
    chk("cpu_rd_ack", 64'(cpu_ack), 64'd1);
    chk("cpu_rd_data", 64'(cpu_dout), 64'h5A);
    cpu_req = 1'b0;
    tick();

    // Single hit on entry 3, row 5.
    poke(11'd12, 8'h40); poke(11'd13, 8'h12); poke(11'd14, 8'hC7); poke(11'd15, 8'h80);
    draw_ready = 1'b1;
    base = n_xfer;
    line_pulse(8'h45);
    chk("single_lb_sel", 64'(lb_sel), 64'(exp_lb));
    chk("single_busy", 64'(busy), 64'd1);
    wait_idle("single_timeout", 3000, cyc);
    chk("single_busy_cycles", 64'(cyc), 64'd1539);
    chk("single_count", 64'(n_xfer - base), 64'd1);
    chk("single_fields", {rec_idx[base], rec_col[base], rec_hpos[base], rec_row[base]},
        {10'h312, 4'h3, 9'h180, 4'd5});
    chk("single_no_ovf", 64'(overflow), 64'd0);

    // Vertical wrap: hit across 255->0, miss in the other direction.
    poke(11'd12, 8'hF8);
    base = n_xfer;
    line_pulse(8'h03);
    wait_idle("wrap_hit_timeout", 3000, cyc);
    chk("wrap_hit_count", 64'(n_xfer - base), 64'd1);
    chk("wrap_hit_row", 64'(rec_row[base]), 64'd11);
    chk("wrap_lb_sel", 64'(lb_sel), 64'(exp_lb));
    poke(11'd12, 8'h03);
    base = n_xfer;
    line_pulse(8'hF8);
    wait_idle("wrap_miss_timeout", 3000, cyc);
    chk("wrap_miss_count", 64'(n_xfer - base), 64'd0);

    // Handshake stall with a CPU read pending.
    poke(11'd12, 8'h40);
    draw_ready = 1'b0;
    base = n_xfer;
    line_pulse(8'h45);
    wait_valid("stall_valid", 100);
    chk("stall_fields", {draw_idx, draw_col, draw_hpos, draw_row}, {10'h312, 4'h3, 9'h180, 4'd5});
    a0 = spr_ram_addr;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h00C;
    stable = 1'b1;
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!draw_valid || draw_idx != 10'h312 || draw_col != 4'h3 ||
          draw_hpos != 9'h180 || draw_row != 4'd5 || spr_ram_addr != a0) stable = 1'b0;
      if (cpu_ack) acks++;
    end
    chk("stall_stable", 64'(stable), 64'd1);
    chk("stall_no_ack", 64'(acks), 64'd0);
    draw_ready = 1'b1;
    cyc = 0;
    while (!cpu_ack && cyc < 10) begin
      cyc++;
      tick();
    end
    chk("stall_ack_latency", 64'(cyc), 64'd2);
    chk("stall_cpu_data", 64'(cpu_dout), 64'h40);
    cpu_req = 1'b0;
    wait_idle("stall_timeout", 3000, cyc);
    chk("stall_count", 64'(n_xfer - base), 64'd1);

    // Hit limit: entries 0..39 all hit at row 8.
    for (int n = 0; n < 40; n++) begin
      poke(11'(4 * n), 8'h48);
      poke(11'(4 * n + 1), 8'(n));
    end
    base = n_xfer;
    line_pulse(8'h50);
    wait_idle("limit_timeout", 3000, cyc);
    chk("limit_count", 64'(n_xfer - base), 64'd32);
    chk("limit_busy_cycles", 64'(cyc), 64'd192);
    chk("limit_overflow", 64'(overflow), 64'd1);
    chk("limit_last", {rec_idx[base + 31], rec_row[base + 31]}, {10'h21F, 4'd8});
    chk("limit_lb_sel", 64'(lb_sel), 64'(exp_lb));

    // Abort: stall on entry 1 (entry 0 is exactly 16 rows away), then restart.
    poke(11'd0, 8'h40);
    draw_ready = 1'b0;
    line_pulse(8'h50);
    chk("abort_ovf_cleared", 64'(overflow), 64'd0);
    wait_valid("abort_valid", 100);
    chk("abort_first_entry", 64'(draw_idx), 64'h201);
    line_start = 1'b1; vline = 8'h45;
    tick();
    line_start = 1'b0;
    exp_lb = ~exp_lb;
    chk("abort_state", {draw_valid, overflow, lb_sel, busy}, {1'b0, 1'b1, exp_lb, 1'b1});
    draw_ready = 1'b1;
    base = n_xfer;
    wait_idle("abort_timeout", 3000, cyc);
    chk("abort_count", 64'(n_xfer - base), 64'd1);
    chk("abort_restart", {rec_idx[base], rec_row[base]}, {10'h200, 4'd5});
    chk("abort_ovf_sticky", 64'(overflow), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sprite_line_sequencer.md
Name: sprite_line_sequencer

Overview:
- Per-scanline controller for the sprite engine. Replaces the PROM microcode sequencing of the sprite-list walk.
- At each line start it scans the sprite attribute RAM (2 KB, 4 bytes per entry), tests vertical hit against the target line, and hands each hit entry to the pixel-fetch/line-buffer writer over a valid/ready handshake.
- Toggles the line-buffer ping-pong select.
- Arbitrates sprite RAM port access between the scan and Z80 requests.

Parameters:
- NUM_SPRITES, 512, entries scanned per line (entry n at byte address 4n).
- MAX_PER_LINE, 32, hits emitted per line before the scan stops.
- SPR_HEIGHT, 16, sprite height in lines (power of two, ≤16).

Ports:
- master_clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- line_start  in  1  one-cycle pulse at start of hblank
- vline  in  8  line being prepared (sampled at line_start)
- spr_ram_addr  out  11  sprite RAM address
- spr_ram_we  out  1  sprite RAM write enable
- spr_ram_din  out  8  write data to sprite RAM
- spr_ram_q  in  8  read data, valid one cycle after address
- cpu_req  in  1  Z80 access request (level, held until ack)
- cpu_we  in  1  1 = write
- cpu_addr  in  11  Z80 address
- cpu_din  in  8  Z80 write data
- cpu_dout  out  8  Z80 read data, valid with cpu_ack
- cpu_ack  out  1  one-cycle completion pulse
- draw_valid  out  1  hit entry presented
- draw_ready  in  1  consumer accepts
- draw_idx  out  10  {xdat[7:6], idx}
- draw_col  out  4  xdat[4:1]
- draw_hpos  out  9  {xdat[0], hpos}
- draw_row  out  4  row within sprite
- lb_sel  out  1  line buffer being written this line
- busy  out  1  scan in progress
- overflow  out  1  sticky per line: hit limit reached or scan aborted by line_start

Behaviour:
- Entry layout at offsets +0..+3: vpos, idx, xdat, hpos.
- Reset: state IDLE; every output 0, including lb_sel and overflow.
- States: IDLE, RD_VPOS, RD_IDX, RD_XDAT, RD_HPOS, EMIT, NEXT.
- line_start, any state:
  - latch vline; toggle lb_sel; clear overflow; entry=0; hits=0; go RD_VPOS.
  - If state was not IDLE, set overflow in the same cycle (abort). A pending draw_valid is dropped.
  - Any CPU access already granted in that cycle completes normally.
- Reads:
  - Each RD_* state presents address 4*entry+k; data is captured one cycle later.
  - Once vpos data is available: row = (vline − vpos) mod 256 (8-bit wrap). Hit iff row < SPR_HEIGHT.
  - Non-hit: skip remaining bytes and go to NEXT.
  - Hit: continue RD_IDX → RD_XDAT → RD_HPOS, then EMIT.
- EMIT:
  - draw_valid=1 with all draw_* fields stable until the cycle draw_ready=1 (transfer).
  - On transfer: hits+1, go NEXT.
  - draw_valid is never asserted outside EMIT.
- NEXT:
  - CPU slot: if cpu_req, perform one CPU access this cycle (spr_ram_addr=cpu_addr, spr_ram_we=cpu_we).
  - Then entry+1. Stop when entry==NUM_SPRITES−1 or hits==MAX_PER_LINE.
  - If stopped by hits==MAX_PER_LINE, set overflow.
  - On stop go IDLE; else RD_VPOS.
- IDLE: CPU access granted in any cycle cpu_req=1.
- CPU access timing:
  - Grant cycle G drives address and we.
  - cpu_ack=1 in G+1; cpu_dout = spr_ram_q in G+1 (reads).
  - A held cpu_req is not re-granted in G+1.
  - Scan never writes: spr_ram_we=1 only in CPU grant cycles.
- busy=1 in every state except IDLE.
- Worst-case CPU latency during scan: one entry (≤6 cycles plus draw_ready stall).

Test Plan:
- Reset then idle:
  - Outputs all 0.
  - CPU write 0x5A @0x123, then read @0x123 → cpu_ack pulse each; cpu_dout=0x5A.
- Single hit:
  - entry 3 = {vpos 0x40, idx 0x12, xdat 0xC7, hpos 0x80}; vline 0x45; draw_ready=1.
  - → exactly one draw_valid with idx=0x312, col=0x3, hpos=0x180, row=5.
  - lb_sel toggles 0→1; busy drops after entry 511.
- Wrap:
  - vpos 0xF8, vline 0x03 → row=11, hit.
  - vpos 0x03, vline 0xF8 → no hit.
- Handshake stall:
  - hit presented with draw_ready=0 for 10 cycles → fields stable, no further RAM scan reads.
  - cpu_req during stall is acked only after transfer (NEXT).
- Limit: 40 hitting entries → 32 draw_valid transfers, overflow=1, busy=0 afterwards.
- Abort: line_start mid-scan → overflow=1, lb_sel toggles, scan restarts at entry 0 with new vline.
